// File: rtl/spike_isi_monitor.sv
// -----------------------------------------------------------------------------
// spike_isi_monitor
//
// Watches the FHN neuron's one-bit firing flag and:
//   * synchronises it and detects clean rising edges,
//   * applies a refractory lockout after each accepted spike,
//   * measures the inter-spike interval (ISI) in clock cycles and hands it out
//     over a valid/ready interface, flagging (sticky) any ISI that had to be
//     dropped because the previous one was still pending,
//   * counts accepted spikes per 2^WIN_BITS-cycle window and shows the count
//     on an 8-segment thermometer LED bar,
//   * optionally drives a fixed-width synaptic pulse to the next neuron.
//
// Build option:
//   SPIKE_MON_SYNOUT_EN  defined   -> syn_out pulses PULSE_LEN cycles per spike
//                        undefined -> no pulse counter, syn_out tied low
//
// Parameters:
//   ISI_W     ISI counter / isi_data width
//   RATE_W    spike-per-window counter width (>= 4 for the LED bar)
//   WIN_BITS  window length is 2^WIN_BITS cycles
//   REFRACT   lockout cycles after an accepted spike (>= 1)
//   PULSE_LEN syn_out high time in cycles (>= 1)
//
// Ports:
//   CLOCK_50     in   system clock
//   RESET        in   synchronous, active-high reset
//   spike_in     in   asynchronous spike level from the neuron
//   isi_data     out  last measured ISI, held while isi_valid is high
//   isi_valid    out  ISI available
//   isi_ready    in   consumer accepts (transfer on isi_valid & isi_ready)
//   isi_overrun  out  sticky: an ISI was dropped while isi_valid was high
//   rate_count   out  spikes counted in the last completed window
//   rate_valid   out  one-cycle pulse when rate_count updates
//   LED          out  thermometer bar of rate_count
//   syn_out      out  synaptic pulse to the next neuron
//
// Latency: spike_in rise in cycle 0 -> edge registered in cycle 3 ->
//          isi_valid / syn_out high in cycle 4.
// -----------------------------------------------------------------------------
module spike_isi_monitor #(
   parameter int ISI_W     = 24,
   parameter int RATE_W    = 16,
   parameter int WIN_BITS  = 20,
   parameter int REFRACT   = 64,
   parameter int PULSE_LEN = 4096
) (
   input  logic              CLOCK_50,
   input  logic              RESET,
   input  logic              spike_in,
   output logic [ISI_W-1:0]  isi_data,
   output logic              isi_valid,
   input  logic              isi_ready,
   output logic              isi_overrun,
   output logic [RATE_W-1:0] rate_count,
   output logic              rate_valid,
   output logic [7:0]        LED,
   output logic              syn_out
);

   // Elaboration-time sanity checks on the configuration.
   if (REFRACT < 1) begin : g_bad_refract
      $error("spike_isi_monitor: REFRACT must be >= 1");
   end
   if (PULSE_LEN < 1) begin : g_bad_pulse_len
      $error("spike_isi_monitor: PULSE_LEN must be >= 1");
   end

   typedef enum logic [1:0] {
      S_IDLE,   // no spike since reset
      S_ARMED,  // measuring, next edge is accepted and emits an ISI
      S_REFR    // lockout after an accepted spike, edges ignored
   } state_t;

   localparam int                REF_W    = $clog2(REFRACT + 1);
   localparam logic [REF_W-1:0]  REF_LAST = REF_W'(REFRACT - 1);

   // ---------------------------------------------------------------------------
   // Synchroniser and registered rising-edge detect.
   // ---------------------------------------------------------------------------
   logic sync1, sync2, sync3, rise_q;

   // NOTE: clocked state is always written with <= so every flop samples the
   // pre-edge value of its neighbour; with = the chain would collapse into one
   // flop in simulation.
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         sync3  <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         sync1  <= spike_in;
         sync2  <= sync1;
         sync3  <= sync2;
         rise_q <= sync2 & ~sync3;
      end
   end

   // ---------------------------------------------------------------------------
   // Spike acceptance FSM.
   // ---------------------------------------------------------------------------
   state_t           state, state_nxt;
   logic [REF_W-1:0] ref_cnt;
   logic             accept;   // edge taken as a real spike
   logic             emit;     // accepted spike that closes an ISI

   always_ff @(posedge CLOCK_50) begin
      if (RESET) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // NOTE: every combinational output gets a default before the case so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (rise_q) state_nxt = S_REFR;
         S_ARMED: if (rise_q) state_nxt = S_REFR;
         S_REFR:  if (ref_cnt == REF_LAST) state_nxt = S_ARMED;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      accept = 1'b0;
      emit   = 1'b0;
      case (state)
         S_IDLE:  accept = rise_q;
         S_ARMED: begin
            accept = rise_q;
            emit   = rise_q;
         end
         default: ;
      endcase
   end

   // Refractory counter: runs only while in S_REFR, so REFR lasts REFRACT cycles.
   always_ff @(posedge CLOCK_50) begin
      if (RESET || state != S_REFR) ref_cnt <= '0;
      else                          ref_cnt <= ref_cnt + 1'b1;
   end

   // ---------------------------------------------------------------------------
   // ISI counter and valid/ready output stage.
   // ---------------------------------------------------------------------------
   logic [ISI_W-1:0] isi_cnt;
   logic [ISI_W-1:0] isi_inc;   // counter + 1, saturating at all-ones

   // The counter is cleared in the accept cycle, so the emitted value
   // (counter + 1) equals the cycle distance between the two accepted edges.
   assign isi_inc = (&isi_cnt) ? isi_cnt : isi_cnt + 1'b1;

   always_ff @(posedge CLOCK_50) begin
      if (RESET || accept)    isi_cnt <= '0;
      else if (state != S_IDLE) isi_cnt <= isi_inc;
   end

   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         isi_data    <= '0;
         isi_valid   <= 1'b0;
         isi_overrun <= 1'b0;
      end else if (emit) begin
         if (!isi_valid || isi_ready) begin
            // Free slot, or the pending value leaves this cycle.
            isi_data  <= isi_inc;
            isi_valid <= 1'b1;
         end else begin
            // Consumer is stalled: keep the old ISI, record the loss.
            isi_overrun <= 1'b1;
         end
      end else if (isi_ready) begin
         isi_valid <= 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Spike rate per window and LED bar.
   // ---------------------------------------------------------------------------
   logic [WIN_BITS-1:0] win_cnt;
   logic [RATE_W-1:0]   spk_cnt;
   logic [RATE_W-1:0]   spk_now;   // spike count including this cycle's spike
   logic                win_wrap;

   assign win_wrap = &win_cnt;
   assign spk_now  = (accept && !(&spk_cnt)) ? spk_cnt + 1'b1 : spk_cnt;

   function automatic logic [7:0] thermo(input logic [RATE_W-1:0] n);
      logic [7:0] t;
      t = '0;
      for (int i = 0; i < 7; i++) t[i] = (n >= RATE_W'(i + 1));
      t[7] = (n >= RATE_W'(8)) || (&n);
      return t;
   endfunction

   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         win_cnt    <= '0;
         spk_cnt    <= '0;
         rate_count <= '0;
         rate_valid <= 1'b0;
         LED        <= '0;
      end else begin
         win_cnt    <= win_cnt + 1'b1;
         rate_valid <= win_wrap;
         if (win_wrap) begin
            rate_count <= spk_now;
            LED        <= thermo(spk_now);
            spk_cnt    <= '0;
         end else begin
            spk_cnt    <= spk_now;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Synaptic output pulse.
   // ---------------------------------------------------------------------------
`ifdef SPIKE_MON_SYNOUT_EN
   localparam int                 PULSE_W    = $clog2(PULSE_LEN + 1);
   localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(PULSE_LEN - 1);

   logic [PULSE_W-1:0] pulse_cnt;   // remaining high cycles after this one

   // Any accepted spike (re)loads the counter, so a retrigger restarts the
   // full PULSE_LEN high time.
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         pulse_cnt <= '0;
         syn_out   <= 1'b0;
      end else if (accept) begin
         pulse_cnt <= PULSE_LAST;
         syn_out   <= 1'b1;
      end else if (pulse_cnt != '0) begin
         pulse_cnt <= pulse_cnt - 1'b1;
      end else begin
         syn_out   <= 1'b0;
      end
   end
`else
   assign syn_out = 1'b0;
`endif

endmodule

// File: tb/tb_spike_isi_monitor.sv
// -----------------------------------------------------------------------------
// tb_spike_isi_monitor
//
// Directed bench for spike_isi_monitor with small parameters (ISI_W=10 so
// saturation is reachable quickly, WIN_BITS=8, REFRACT=16, PULSE_LEN=8).
// Cycle numbers below count from the first cycle after reset release; a spike
// "rise at c" means spike_in goes high in cycle c for three cycles.
// -----------------------------------------------------------------------------
module tb_spike_isi_monitor;

   localparam int ISI_W     = 10;
   localparam int RATE_W    = 16;
   localparam int WIN_BITS  = 8;
   localparam int REFRACT   = 16;
   localparam int PULSE_LEN = 8;
   localparam int ISI_MAX   = (1 << ISI_W) - 1;

`ifdef SPIKE_MON_SYNOUT_EN
   localparam bit SYN_EN = 1'b1;
`else
   localparam bit SYN_EN = 1'b0;
`endif

   logic              CLOCK_50 = 1'b0;
   logic              RESET    = 1'b1;
   logic              spike_in = 1'b0;
   logic              isi_ready = 1'b1;
   logic [ISI_W-1:0]  isi_data;
   logic              isi_valid;
   logic              isi_overrun;
   logic [RATE_W-1:0] rate_count;
   logic              rate_valid;
   logic [7:0]        LED;
   logic              syn_out;

   spike_isi_monitor #(
      .ISI_W    (ISI_W),
      .RATE_W   (RATE_W),
      .WIN_BITS (WIN_BITS),
      .REFRACT  (REFRACT),
      .PULSE_LEN(PULSE_LEN)
   ) dut (
      .CLOCK_50   (CLOCK_50),
      .RESET      (RESET),
      .spike_in   (spike_in),
      .isi_data   (isi_data),
      .isi_valid  (isi_valid),
      .isi_ready  (isi_ready),
      .isi_overrun(isi_overrun),
      .rate_count (rate_count),
      .rate_valid (rate_valid),
      .LED        (LED),
      .syn_out    (syn_out)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int rises[$];
   int hold_from = 32'h7fff_ffff;   // spike_in held high from this cycle on

   typedef struct {
      string name;
      int    gap;        // cycles between first and second rise
      bit    accepted;   // second spike expected to produce an ISI
      int    exp_isi;
   } isi_vec_t;

   isi_vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic spike_level(input int c);
      if (c >= hold_from) return 1'b1;
      for (int i = 0; i < rises.size(); i++)
         if (c >= rises[i] && c < rises[i] + 3) return 1'b1;
      return 1'b0;
   endfunction

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic step();
      @(posedge CLOCK_50);
      #1;
      cyc++;
      spike_in = spike_level(cyc);
   endtask

   task automatic run_to(input int n);
      while (cyc < n) step();
   endtask

   task automatic do_reset();
      RESET    = 1'b1;
      spike_in = 1'b0;
      repeat (2) begin
         @(posedge CLOCK_50);
         #1;
      end
      RESET    = 1'b0;
      cyc      = 0;
      spike_in = spike_level(0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bit saw_valid;

      vecs.push_back('{"isi_min_gap",   17, 1'b1, 17});
      vecs.push_back('{"isi_refr_last", 16, 1'b0, 0});
      vecs.push_back('{"isi_gap50",     50, 1'b1, 50});
      vecs.push_back('{"isi_gap100",   100, 1'b1, 100});
      vecs.push_back('{"isi_near_sat",1022, 1'b1, 1022});
      vecs.push_back('{"isi_at_max",  1023, 1'b1, ISI_MAX});
      vecs.push_back('{"isi_sat",     1024, 1'b1, ISI_MAX});

      // ---- reset values --------------------------------------------------
      rises = {};
      do_reset();
      check("rst_isi_data",    32'(isi_data),    0);
      check("rst_isi_valid",   32'(isi_valid),   0);
      check("rst_isi_overrun", 32'(isi_overrun), 0);
      check("rst_rate_count",  32'(rate_count),  0);
      check("rst_rate_valid",  32'(rate_valid),  0);
      check("rst_led",         32'(LED),         0);
      check("rst_syn_out",     32'(syn_out),     0);

      // ---- table: pairs of spikes at various gaps ------------------------
      for (int v = 0; v < vecs.size(); v++) begin
         rises = {0, vecs[v].gap};
         do_reset();
         run_to(vecs[v].gap + 4);
         check({vecs[v].name, "_valid"}, 32'(isi_valid), 32'(vecs[v].accepted));
         if (vecs[v].accepted)
            check({vecs[v].name, "_data"}, 32'(isi_data), 32'(vecs[v].exp_isi));
         check({vecs[v].name, "_overrun"}, 32'(isi_overrun), 0);
      end

      // ---- spikes at 10 and 110: first emits nothing, ISI=100 at 114 -----
      rises = {10, 110};
      do_reset();
      run_to(14);
      check("first_no_isi", 32'(isi_valid), 0);
      run_to(113);
      check("isi100_early", 32'(isi_valid), 0);
      run_to(114);
      check("isi100_valid",   32'(isi_valid),   1);
      check("isi100_data",    32'(isi_data),    100);
      check("isi100_overrun", 32'(isi_overrun), 0);
      run_to(115);
      check("isi100_xfer", 32'(isi_valid), 0);

      // ---- refractory: rises at 0, 8 (ignored), 50 -----------------------
      rises = {0, 8, 50};
      do_reset();
      run_to(12);
      check("refr_ignored", 32'(isi_valid), 0);
      run_to(54);
      check("refr_valid", 32'(isi_valid), 1);
      check("refr_data",  32'(isi_data),  50);

      // ---- overrun with stalled consumer, then transfer, then reset ------
      rises = {0, 100, 200, 300};
      isi_ready = 1'b0;
      do_reset();
      run_to(104);
      check("ovr_first_valid", 32'(isi_valid), 1);
      check("ovr_first_data",  32'(isi_data),  100);
      check("ovr_first_flag",  32'(isi_overrun), 0);
      run_to(204);
      check("ovr_held_data", 32'(isi_data),    100);
      check("ovr_flag",      32'(isi_overrun), 1);
      run_to(210);
      isi_ready = 1'b1;
      check("ovr_before_xfer", 32'(isi_valid), 1);
      step();
      check("ovr_after_xfer", 32'(isi_valid),   0);
      check("ovr_sticky",     32'(isi_overrun), 1);
      isi_ready = 1'b0;
      run_to(304);
      check("ovr_pending_valid", 32'(isi_valid), 1);
      check("ovr_pending_data",  32'(isi_data),  100);
      RESET = 1'b1;
      step();
      check("midrst_valid",   32'(isi_valid),   0);
      check("midrst_data",    32'(isi_data),    0);
      check("midrst_overrun", 32'(isi_overrun), 0);
      RESET = 1'b0;
      isi_ready = 1'b1;

      // ---- rate windows: 5 spikes, empty window, spike on the wrap -------
      rises = {0, 20, 40, 60, 80, 764};
      do_reset();
      run_to(255);
      check("rate_no_early_pulse", 32'(rate_valid), 0);
      run_to(256);
      check("rate1_valid", 32'(rate_valid), 1);
      check("rate1_count", 32'(rate_count), 5);
      check("rate1_led",   32'(LED),        32'h1F);
      run_to(257);
      check("rate1_pulse_end", 32'(rate_valid), 0);
      check("rate1_held",      32'(rate_count), 5);
      run_to(512);
      check("rate2_valid", 32'(rate_valid), 1);
      check("rate2_count", 32'(rate_count), 0);
      check("rate2_led",   32'(LED),        0);
      run_to(768);
      check("rate3_wrap_spike", 32'(rate_count), 1);
      check("rate3_led",        32'(LED),        32'h01);

      // ---- held-high spike_in is a single edge ---------------------------
      rises = {};
      hold_from = 0;
      do_reset();
      saw_valid = 1'b0;
      while (cyc < 256) begin
         step();
         if (isi_valid) saw_valid = 1'b1;
      end
      check("held_high_no_isi",  32'(saw_valid),  0);
      check("held_high_one_spk", 32'(rate_count), 1);
      hold_from = 32'h7fff_ffff;

      // ---- synaptic pulse and reset mid-pulse ----------------------------
      rises = {0, 20};
      do_reset();
      for (int c = 0; c <= 14; c++) begin
         run_to(c);
         check($sformatf("syn_c%0d", c), 32'(syn_out),
               32'(SYN_EN && c >= 4 && c < 4 + PULSE_LEN));
      end
      run_to(26);
      check("syn_second", 32'(syn_out), 32'(SYN_EN));
      RESET = 1'b1;
      step();
      check("syn_midrst", 32'(syn_out), 0);
      RESET = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spike_isi_monitor.md
# spike_isi_monitor

Downstream consumer of the FHN neuron's spike output (the one-bit firing flag driven to GPIO_1). Synchronises the spike line, accepts clean rising edges with a refractory lockout, measures inter-spike interval (ISI) in clock cycles, and counts spikes per fixed window. ISIs go out through a valid/ready handshake, the spike rate drives an LED bar, and an optional fixed-width synaptic pulse is produced for the next neuron's input pin.

## Interface
- ISI_W, 24: ISI counter/output width.
- RATE_W, 16: spike-per-window counter width.
- WIN_BITS, 20: window length = 2^WIN_BITS cycles.
- REFRACT, 64: cycles after an accepted spike during which further edges are ignored (≥1).
- PULSE_LEN, 4096: syn_out high time in cycles (≥1).

Ports:
- CLOCK_50  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- spike_in  in  1  asynchronous spike level from the neuron.
- isi_data  out  ISI_W  last measured ISI, held while isi_valid=1.
- isi_valid  out  1  ISI available.
- isi_ready  in  1  consumer accepts; transfer when isi_valid&isi_ready.
- isi_overrun  out  1  sticky: an ISI was dropped because isi_valid was still high.
- rate_count  out  RATE_W  spikes in last completed window.
- rate_valid  out  1  one-cycle pulse when rate_count updates.
- LED  out  8  thermometer bar of rate_count.
- syn_out  out  1  synaptic pulse to next neuron.

## Operation
- Input: 2-flop synchroniser, then edge detect (sync2 & ~sync3). "Edge" below = this detected rising edge.
- State machine:
  - IDLE: no spike seen since reset. Edge → accept, clear ISI counter, go REFR. No ISI emitted for the first spike.
  - ARMED: ISI counter increments each cycle, saturating at all-ones. Edge → accept, emit ISI = counter+1 (saturated stays all-ones), clear counter, go REFR.
  - REFR: counter keeps incrementing; refractory counter counts REFRACT cycles, then → ARMED. Edges in REFR are ignored (not counted, not emitted).
- ISI = cycles between the two accepted edges.
- ISI output: on emit, if isi_valid=0 load isi_data, set isi_valid. If isi_valid=1 and isi_ready=1 in the same cycle, load the new value and keep isi_valid=1. If isi_valid=1 and isi_ready=0, drop the new ISI, set isi_overrun (cleared only by RESET). isi_valid clears on transfer with no new emit.
- Rate: free-running WIN_BITS-bit window counter. Every accepted spike increments spike counter (saturates at all-ones). On window wrap: rate_count ← spike counter (including a spike accepted that same cycle), spike counter ← 0, rate_valid pulses.
- LED[i] = 1 when rate_count > i·(2^RATE_W/8)... no: LED[i] = (rate_count ≥ i+1) for i=0..6; LED[7] = (rate_count ≥ 8) or saturated. LED registered, updates with rate_count.
- syn_out: see Configuration. Retrigger during pulse restarts the PULSE_LEN count.

## Timing
- Reset values: isi_data=0, isi_valid=0, isi_overrun=0, rate_count=0, rate_valid=0, LED=0, syn_out=0; state IDLE; all counters 0; synchroniser flops 0.
- RESET mid-operation: everything returns to reset values next cycle; pending ISI discarded.
- Latency: spike_in rise at cycle 0 → edge detected cycle 3 → isi_valid / syn_out high cycle 4.
- isi_data stable while isi_valid=1 and isi_ready=0.
- rate_valid high exactly one cycle per 2^WIN_BITS cycles, first after 2^WIN_BITS cycles from reset release.
- Held-high spike_in produces one edge only.

## Configuration
- SPIKE_MON_SYNOUT_EN defined: each accepted spike drives syn_out high for PULSE_LEN cycles starting cycle 4 after spike_in rise.
- Undefined: pulse counter not built; syn_out tied 0. All other behaviour identical.

## Test plan
(WIN_BITS=8, REFRACT=16, PULSE_LEN=8, isi_ready=1 unless stated.)
- Reset then spike_in pulses rising at cycles 10 and 110 → no ISI for first; isi_valid with isi_data=100 at cycle 114; isi_overrun=0.
- Second rise 8 cycles after first (inside REFRACT) then third at +50 from first → only third accepted, isi_data=50.
- isi_ready=0, three spikes 100 apart → isi_data=100 held, isi_overrun=1; raise isi_ready → one transfer, isi_valid drops.
- 5 accepted spikes inside one 256-cycle window → rate_valid pulse with rate_count=5, LED=8'h1F; empty next window → rate_count=0, LED=0.
- No second spike for 2^24+ cycles after first, then spike → isi_data=24'hFFFFFF.
- With SPIKE_MON_SYNOUT_EN, single spike → syn_out high exactly 8 cycles; RESET asserted mid-pulse → syn_out=0 next cycle; without macro syn_out stays 0.
